// File: rtl/mc_datapath.sv
// ============================================================================
// mc_datapath : multi-cycle MIPS datapath (PC, IR, MDR, A, B, ALUOut, RF, ALU)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  AluOp,
  input  logic        AluSrcA,
  input  logic [1:0]  AluSrcB,
  input  logic        IorD,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic        IRwrite,
  input  logic        PCwrite,
  input  logic        PCwritecondbeq,
  input  logic        PCwritecondbne,
  input  logic [1:0]  PCsrc,
  input  logic        Regwrite,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  Memtoreg,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Func,
  output logic        zero,
  output logic [31:0] pc_out
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] aluout_q;
  logic [31:0] rf_q [32];

  logic [31:0] imm_ext;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] alu_res;
  logic [31:0] jump_tgt;
  logic        pc_we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign imm_ext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jump_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    opa = AluSrcA ? a_q : pc_q;
    opb = b_q;
    case (AluSrcB)
      2'b00:   opb = b_q;
      2'b01:   opb = 32'd4;
      2'b10:   opb = imm_ext;
      default: opb = {imm_ext[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_res = 32'h0;
    case (AluOp)
      ALU_ADD: alu_res = opa + opb;
      ALU_SUB: alu_res = opa - opb;
      ALU_AND: alu_res = opa & opb;
      ALU_OR:  alu_res = opa | opb;
      ALU_SLT: alu_res = ($signed(opa) < $signed(opb)) ? 32'd1 : 32'd0;
      default: alu_res = 32'h0;
    endcase
  end

  assign zero  = (alu_res == 32'h0);
  assign pc_we = PCwrite | (PCwritecondbeq & zero) | (PCwritecondbne & ~zero);

  always_comb begin
    pc_d = pc_q;
    if (pc_we) begin
      case (PCsrc)
        2'b00:   pc_d = alu_res;
        2'b01:   pc_d = jump_tgt;
        2'b10:   pc_d = aluout_q;
        default: pc_d = a_q;
      endcase
    end
  end

  always_comb begin
    wr_addr = ir_q[20:16];
    case (RegDst)
      2'b01:   wr_addr = ir_q[15:11];
      2'b10:   wr_addr = 5'd31;
      default: wr_addr = ir_q[20:16];
    endcase
  end

  // The link value is the PC as it stands, already advanced past the jal.
  always_comb begin
    wr_data = aluout_q;
    case (Memtoreg)
      2'b01:   wr_data = mdr_q;
      2'b10:   wr_data = pc_q;
      default: wr_data = aluout_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      mdr_q    <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      aluout_q <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      mdr_q    <= mem_rdata;
      a_q      <= rf_q[ir_q[25:21]];
      b_q      <= rf_q[ir_q[20:16]];
      aluout_q <= alu_res;
      if (IRwrite) begin
        ir_q <= mem_rdata;
      end
    end
  end

  // $0 is never written, so it reads zero without a read-side mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0;
      end
    end else if (Regwrite && (wr_addr != 5'd0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_rd    = Memread;
  assign mem_wr    = Memwrite;
  assign OpCode    = ir_q[31:26];
  assign Func      = ir_q[5:0];
  assign pc_out    = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_datapath.sv
// ============================================================================
// tb_mc_datapath : directed self-checking bench for mc_datapath
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mc_datapath;

  logic        clk;
  logic        rst;
  logic [2:0]  AluOp;
  logic        AluSrcA;
  logic [1:0]  AluSrcB;
  logic        IorD;
  logic        Memread;
  logic        Memwrite;
  logic        IRwrite;
  logic        PCwrite;
  logic        PCwritecondbeq;
  logic        PCwritecondbne;
  logic [1:0]  PCsrc;
  logic        Regwrite;
  logic [1:0]  RegDst;
  logic [1:0]  Memtoreg;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [5:0]  OpCode;
  logic [5:0]  Func;
  logic        zero;
  logic [31:0] pc_out;

  logic [31:0] mem [256];
  int          checks;
  int          errors;

  mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .AluOp          (AluOp),
    .AluSrcA        (AluSrcA),
    .AluSrcB        (AluSrcB),
    .IorD           (IorD),
    .Memread        (Memread),
    .Memwrite       (Memwrite),
    .IRwrite        (IRwrite),
    .PCwrite        (PCwrite),
    .PCwritecondbeq (PCwritecondbeq),
    .PCwritecondbne (PCwritecondbne),
    .PCsrc          (PCsrc),
    .Regwrite       (Regwrite),
    .RegDst         (RegDst),
    .Memtoreg       (Memtoreg),
    .mem_rdata      (mem_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .OpCode         (OpCode),
    .Func           (Func),
    .zero           (zero),
    .pc_out         (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    AluOp = 3'b000; AluSrcA = 1'b0; AluSrcB = 2'b00; IorD = 1'b0;
    Memread = 1'b0; Memwrite = 1'b0; IRwrite = 1'b0; PCwrite = 1'b0;
    PCwritecondbeq = 1'b0; PCwritecondbne = 1'b0; PCsrc = 2'b00;
    Regwrite = 1'b0; RegDst = 2'b00; Memtoreg = 2'b00;
  endtask

  task automatic fetch(input logic [31:0] instr);
    mem[pc_out[9:2]] = instr;
    idle();
    AluSrcB = 2'b01; PCwrite = 1'b1; IRwrite = 1'b1; Memread = 1'b1;
    tick();
    idle();
  endtask

  // ID cycle: branch target into ALUOut, A/B loaded from rs/rt.
  task automatic decode();
    idle();
    AluSrcB = 2'b11;
    tick();
    idle();
  endtask

  task automatic addi(input logic [4:0] rt, input logic [15:0] imm);
    fetch({6'b001000, 5'd0, rt, imm});
    decode();
    AluSrcA = 1'b1; AluSrcB = 2'b10;
    tick();
    idle();
    Regwrite = 1'b1;
    tick();
    idle();
  endtask

  task automatic branch(input logic beq, input logic bne);
    idle();
    AluSrcA = 1'b1; AluOp = 3'b001; PCsrc = 2'b10;
    PCwritecondbeq = beq; PCwritecondbne = bne;
    tick();
    idle();
  endtask

  task automatic alu_probe(input logic [2:0] op, input logic [31:0] exp, input string tag);
    idle();
    AluSrcA = 1'b1; AluOp = op;
    tick();
    check(tag, dut.aluout_q, exp);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    idle();
    rst = 1'b1;
    #12;
    check("reset_pc", pc_out, 32'h0);
    check("reset_opcode", {26'h0, OpCode}, 32'h0);
    check("reset_func", {26'h0, Func}, 32'h0);
    check("reset_zero", {31'h0, zero}, 32'h1);
    check("reset_rf8", dut.rf_q[8], 32'h0);
    tick();
    rst = 1'b0;

    // Fetch + addi $8,$0,5
    mem[0] = 32'h2008_0005;
    AluSrcB = 2'b01; PCwrite = 1'b1; IRwrite = 1'b1; Memread = 1'b1;
    #1;
    check("if_mem_addr", mem_addr, 32'h0);
    check("if_mem_rd", {31'h0, mem_rd}, 32'h1);
    tick();
    idle();
    check("if_pc", pc_out, 32'h4);
    check("if_ir", dut.ir_q, 32'h2008_0005);
    check("if_opcode", {26'h0, OpCode}, 32'h8);
    decode();
    AluSrcA = 1'b1; AluSrcB = 2'b10;
    tick();
    idle();
    check("addi_aluout", dut.aluout_q, 32'h5);
    check("addi_rf8_before", dut.rf_q[8], 32'h0);
    Regwrite = 1'b1;
    tick();
    idle();
    check("addi_rf8", dut.rf_q[8], 32'h5);

    // Branches from a clean PC = 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addi(5'd1, 16'd7);
    addi(5'd2, 16'd7);
    check("pc_after_addis", pc_out, 32'h8);
    fetch({6'b000100, 5'd1, 5'd2, 16'd3});
    decode();
    check("id_branch_target", dut.aluout_q, 32'd24);
    idle();
    AluSrcA = 1'b1; AluOp = 3'b001;
    #1;
    check("beq_zero_eq", {31'h0, zero}, 32'h1);
    branch(1'b1, 1'b0);
    check("beq_taken_pc", pc_out, 32'd24);
    fetch({6'b000101, 5'd1, 5'd2, 16'd3});
    decode();
    branch(1'b0, 1'b1);
    check("bne_not_taken_pc", pc_out, 32'd28);
    addi(5'd2, 16'd8);
    fetch({6'b000100, 5'd1, 5'd2, 16'd3});
    decode();
    branch(1'b1, 1'b0);
    check("beq_not_taken_pc", pc_out, 32'd36);
    fetch({6'b000101, 5'd1, 5'd2, 16'd3});
    decode();
    branch(1'b0, 1'b1);
    check("bne_taken_pc", pc_out, 32'd52);
    fetch({6'b000100, 5'd1, 5'd2, 16'd3});
    decode();
    branch(1'b1, 1'b1);
    check("both_cond_pc", pc_out, 32'd68);

    // jr to 0x100, then jal
    addi(5'd9, 16'h0100);
    fetch({6'b000000, 5'd9, 5'd0, 5'd0, 5'd0, 6'b001000});
    check("jr_func", {26'h0, Func}, 32'h8);
    decode();
    PCwrite = 1'b1; PCsrc = 2'b11;
    tick();
    idle();
    check("jr_pc_100", pc_out, 32'h100);
    fetch(32'h0C00_0040);
    check("jal_pc", pc_out, 32'h104);
    check("jal_ir", dut.ir_q, 32'h0C00_0040);
    Regwrite = 1'b1; RegDst = 2'b10; Memtoreg = 2'b10;
    tick();
    idle();
    check("jal_link", dut.rf_q[31], 32'h104);
    PCwrite = 1'b1; PCsrc = 2'b01;
    tick();
    idle();
    check("jal_pc_target", pc_out, 32'h100);
    addi(5'd9, 16'h0200);
    fetch({6'b000000, 5'd9, 5'd0, 5'd0, 5'd0, 6'b001000});
    decode();
    PCwrite = 1'b1; PCsrc = 2'b11;
    tick();
    idle();
    check("jr_pc_200", pc_out, 32'h200);

    // sw / lw / $0
    addi(5'd10, 16'd16);
    addi(5'd11, 16'hFFFD);
    check("rf11_neg", dut.rf_q[11], 32'hFFFF_FFFD);
    fetch({6'b101011, 5'd10, 5'd11, 16'd4});
    decode();
    AluSrcA = 1'b1; AluSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1; Memwrite = 1'b1;
    #1;
    check("sw_addr", mem_addr, 32'd20);
    check("sw_wr", {31'h0, mem_wr}, 32'h1);
    check("sw_wdata", mem_wdata, 32'hFFFF_FFFD);
    tick();
    idle();
    check("sw_mem", mem[5], 32'hFFFF_FFFD);
    fetch({6'b100011, 5'd10, 5'd12, 16'd4});
    decode();
    AluSrcA = 1'b1; AluSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1; Memread = 1'b1;
    tick();
    idle();
    check("lw_mdr", dut.mdr_q, 32'hFFFF_FFFD);
    Regwrite = 1'b1; Memtoreg = 2'b01;
    tick();
    idle();
    check("lw_rf12", dut.rf_q[12], 32'hFFFF_FFFD);
    fetch(32'h2000_FFFF);
    decode();
    AluSrcA = 1'b1; AluSrcB = 2'b10;
    tick();
    idle();
    check("r0_data", dut.aluout_q, 32'hFFFF_FFFF);
    Regwrite = 1'b1;
    tick();
    idle();
    check("r0_stays_zero", dut.rf_q[0], 32'h0);

    // ALU ops with A = -3, B = 16
    fetch({6'b000000, 5'd11, 5'd10, 5'd0, 5'd0, 6'd0});
    decode();
    alu_probe(3'b000, 32'd13, "alu_add");
    alu_probe(3'b001, 32'hFFFF_FFED, "alu_sub");
    alu_probe(3'b010, 32'h10, "alu_and");
    alu_probe(3'b011, 32'hFFFF_FFFD, "alu_or");
    alu_probe(3'b100, 32'h1, "alu_slt_true");
    idle();
    AluSrcA = 1'b1; AluOp = 3'b101;
    #1;
    check("alu_undef_zero", {31'h0, zero}, 32'h1);
    tick();
    check("alu_undef", dut.aluout_q, 32'h0);
    idle();
    AluOp = 3'b100;
    tick();
    check("alu_slt_false", dut.aluout_q, 32'h0);
    idle();

    // Async reset in the middle of a lw
    fetch({6'b100011, 5'd10, 5'd13, 16'd4});
    decode();
    AluSrcA = 1'b1; AluSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1; Memread = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc_out, 32'h0);
    check("async_rst_ir", dut.ir_q, 32'h0);
    check("async_rst_opcode", {26'h0, OpCode}, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    check("async_rst_rf13", dut.rf_q[13], 32'h0);
    check("async_rst_rf10", dut.rf_q[10], 32'h0);
    check("async_rst_pc_hold", pc_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Multi-cycle MIPS datapath that executes the control word produced by the FSM controller each cycle. It holds PC, IR, MDR, A, B, ALUOut and the 32x32 register file, and contains the ALU and the next-PC logic. It drives the shared instruction/data memory port and returns OpCode, Func and zero to the controller. It sits between the controller and the unified memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
AluOp  input  3  000 add, 001 sub, 010 and, 011 or, 100 slt (signed); other codes give result 0.
AluSrcA  input  1  0 = PC, 1 = A.
AluSrcB  input  2  00 = B, 01 = 32'd4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
IorD  input  1  memory address: 0 = PC, 1 = ALUOut.
Memread  input  1  memory read strobe, forwarded to mem_rd.
Memwrite  input  1  memory write strobe, forwarded to mem_wr.
IRwrite  input  1  IR load enable.
PCwrite  input  1  unconditional PC write.
PCwritecondbeq  input  1  PC write if zero = 1.
PCwritecondbne  input  1  PC write if zero = 0.
PCsrc  input  2  00 = ALU result, 01 = jump target, 10 = ALUOut, 11 = A.
Regwrite  input  1  register file write enable.
RegDst  input  2  00 = rt, 01 = rd, 10 = 5'd31, 11 = rt.
Memtoreg  input  2  00 = ALUOut, 01 = MDR, 10 = PC, 11 = ALUOut.
mem_rdata  input  32  combinational read data from memory.
mem_addr  output  32  memory address.
mem_wdata  output  32  store data; equals B.
mem_rd  output  1  equals Memread.
mem_wr  output  1  equals Memwrite.
OpCode  output  6  IR[31:26].
Func  output  6  IR[5:0].
zero  output  1  1 when the current-cycle ALU result is 32'h0.
pc_out  output  32  current PC, for debug and trace.

Behaviour:
- Reset (async, rst high):
  - PC = RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 registers = 0.
  - With IRwrite = 0, OpCode and Func therefore read 0.
  - Reset asserted mid-instruction discards all in-flight state; no partial register or PC write survives.
- Register updates at each posedge:
  - MDR <= mem_rdata every cycle.
  - A <= rf[IR[25:21]] and B <= rf[IR[20:16]] every cycle.
  - ALUOut <= ALU result every cycle.
  - IR <= mem_rdata only when IRwrite = 1.
- ALU: combinational, 32-bit, wrap-around add/sub with no overflow trap.
  - slt gives 32'd1 when signed operand A < operand B, else 0.
  - zero reflects this cycle's ALU result, not ALUOut.
- Next PC:
  - Jump target = {PC[31:28], IR[25:0], 2'b00}, built from the already-incremented PC.
  - PC write enable = PCwrite | (PCwritecondbeq & zero) | (PCwritecondbne & ~zero).
  - When enabled, PC <= value selected by PCsrc.
  - PCwritecondbeq and PCwritecondbne both asserted: PC always written (condition ORed).
- Register file:
  - Write at posedge when Regwrite = 1, to the register selected by RegDst, with data selected by Memtoreg.
  - Writes to $0 are ignored; $0 always reads 0.
  - Reads are combinational. A same-cycle write and read of one register gives the old value to A/B; the new value is visible the next cycle.
  - Memtoreg = 10 (jal link) writes the current PC, which already holds PC+4 after IF.
- Memory interface:
  - mem_addr = IorD ? ALUOut : PC.
  - No alignment check; the low 2 address bits are passed through unchanged.
  - mem_rd and mem_wr are pure pass-through; the datapath adds no wait states.
- Latency: PC, IR and register file writes take effect one clock after the control word is presented.

Test Plan:
- Fetch: reset, PC = 0, mem[0] = 32'h2008_0005 (addi $8,$0,5); apply IF word (AluSrcA=0, AluSrcB=01, AluOp=000, PCsrc=00, PCwrite=1, IRwrite=1, Memread=1) -> PC = 4, IR = 32'h2008_0005, OpCode = 6'b001000.
- addi: then ID word, then AluSrcA=1, AluSrcB=10, AluOp=000, then Regwrite=1, RegDst=00, Memtoreg=00 -> rf[8] = 5; ALUOut = 5 one cycle before the write.
- beq taken vs not taken: rf[1] = rf[2] = 7 and offset 3 -> after ID (AluSrcB=11) plus branch cycle (AluOp=001, PCwritecondbeq=1, PCsrc=10), PC = 4+12 = 16; with rf[2] = 8, PC stays 4. Repeat with PCwritecondbne for the inverse outcome.
- jal/jr: at PC = 32'h0000_0104 (after IF), IR = 32'h0C00_0040 -> link cycle writes rf[31] = 32'h104; jump cycle gives PC = 32'h100. jr with A = 32'h200 and PCsrc=11 -> PC = 32'h200.
- lw/sw and $0: sw with base 16 and offset 4 -> mem_addr = 20, mem_wr = 1, mem_wdata = B. lw from 20 -> MDR latched, written to rt. Regwrite to $0 with data 32'hFFFF_FFFF -> $0 still reads 0.
- Async reset mid-lw (between address and MDR cycles) -> PC = RESET_PC and IR = 0 immediately, not at the next clock edge; target register unchanged.
